// File: rtl/ov7670_timing_gen.sv
// OV7670-style camera source: derives p_clock from xclk and emits vsync,
// href and 8-bit pixel bytes for configurable test patterns and formats.
module ov7670_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BACK   = 17,
    parameter int unsigned PCLK_DIV = 2,
    parameter int unsigned TRUNC_W  = 10
) (
    input  logic               xclk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic               fmt,
    input  logic [15:0]        const_pix,
    input  logic               trunc_en,
    input  logic [TRUNC_W-1:0] trunc_cnt,
    output logic               p_clock,
    output logic               vsync,
    output logic               href,
    output logic [7:0]         p_data,
    output logic [15:0]        frame_cnt,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned LINE_P  = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned FRONT_P = V_FRONT * LINE_P;
    localparam int unsigned SYNC_P  = V_SYNC * LINE_P;
    localparam int unsigned BACK_P  = V_BACK * LINE_P;
    localparam int unsigned ACT_P   = 2 * H_ACTIVE;
    localparam int unsigned M1      = (FRONT_P > SYNC_P) ? FRONT_P : SYNC_P;
    localparam int unsigned M2      = (M1 > BACK_P) ? M1 : BACK_P;
    localparam int unsigned M3      = (M2 > ACT_P) ? M2 : ACT_P;
    localparam int unsigned MAX_P   = (M3 > H_BLANK) ? M3 : H_BLANK;
    localparam int unsigned CNT_W   = $clog2(MAX_P + 1);
    localparam int unsigned LINE_W  = $clog2(V_ACTIVE + 1);
    localparam int unsigned DIV_W   = $clog2(PCLK_DIV);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FRONT  = 3'd1;
    localparam logic [2:0] S_SYNC   = 3'd2;
    localparam logic [2:0] S_BACK   = 3'd3;
    localparam logic [2:0] S_ACTIVE = 3'd4;
    localparam logic [2:0] S_HBLANK = 3'd5;

    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINE_W-1:0]  r_line;
    logic [1:0]         r_mode;
    logic               r_fmt;
    logic [15:0]        r_const_pix;
    logic               r_trunc_en;
    logic [TRUNC_W-1:0] r_trunc_cnt;

    logic               w_tick;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [LINE_W-1:0]  w_line_nxt;
    logic               w_frame_end;
    logic               w_latch;
    logic [15:0]        w_x;
    logic [7:0]         w_y;
    logic [2:0]         w_bar;
    logic [15:0]        w_pix;
    logic [7:0]         w_byte;
    logic               w_trunc;

    assign w_tick = (r_div == DIV_W'(PCLK_DIV - 1));

    // Free-running pixel-clock divider: p_clock falls on the tick, rises half a period later
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            p_clock <= 1'b0;
        end else if (w_tick) begin
            r_div   <= '0;
            p_clock <= 1'b0;
        end else begin
            r_div <= r_div + DIV_W'(1);
            if (r_div == DIV_W'(PCLK_DIV / 2 - 1)) begin
                p_clock <= 1'b1;
            end
        end
    end

    // Frame position register, advanced once per pclk period
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
        end else if (w_tick) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_line  <= w_line_nxt;
        end
    end

    // Next frame position; the frame always runs to completion once started
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_line_nxt  = r_line;
        w_frame_end = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = S_FRONT;
                    w_latch     = 1'b1;
                end
            end
            S_FRONT: begin
                if (r_cnt == CNT_W'(FRONT_P - 1)) begin
                    w_state_nxt = S_SYNC;
                    w_cnt_nxt   = '0;
                end
            end
            S_SYNC: begin
                if (r_cnt == CNT_W'(SYNC_P - 1)) begin
                    w_state_nxt = S_BACK;
                    w_cnt_nxt   = '0;
                end
            end
            S_BACK: begin
                if (r_cnt == CNT_W'(BACK_P - 1)) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                    w_line_nxt  = '0;
                end
            end
            S_ACTIVE: begin
                if (r_cnt == CNT_W'(ACT_P - 1)) begin
                    w_state_nxt = S_HBLANK;
                    w_cnt_nxt   = '0;
                end
            end
            S_HBLANK: begin
                if (r_cnt == CNT_W'(H_BLANK - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_line == LINE_W'(V_ACTIVE - 1)) begin
                        w_frame_end = 1'b1;
                        w_line_nxt  = '0;
                        if (enable) begin
                            w_state_nxt = S_FRONT;
                            w_latch     = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = S_ACTIVE;
                        w_line_nxt  = r_line + LINE_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pattern pixel and byte for the upcoming pclk period
    always_comb begin
        w_x   = 16'(w_cnt_nxt >> 1);
        w_y   = 8'(w_line_nxt);
        w_bar = 3'(32'(w_x) / BAR_W);
        w_pix = 16'h0000;
        case (r_mode)
            2'd0: begin
                case (w_bar)
                    3'd0:    w_pix = 16'hFFFF;
                    3'd1:    w_pix = 16'hFFE0;
                    3'd2:    w_pix = 16'h07FF;
                    3'd3:    w_pix = 16'h07E0;
                    3'd4:    w_pix = 16'hF81F;
                    3'd5:    w_pix = 16'hF800;
                    3'd6:    w_pix = 16'h001F;
                    default: w_pix = 16'h0000;
                endcase
            end
            2'd1:    w_pix = {w_x[4:0], w_x[5:0], w_x[4:0]};
            2'd2:    w_pix = r_const_pix;
            default: w_pix = {frame_cnt[7:0], w_y};
        endcase
        if (r_fmt) begin
            w_byte = w_cnt_nxt[0] ? {w_pix[10:7], w_pix[4:1]} : {4'h0, w_pix[15:12]};
        end else begin
            w_byte = w_cnt_nxt[0] ? w_pix[7:0] : w_pix[15:8];
        end
        w_trunc = r_trunc_en && (w_line_nxt == LINE_W'(V_ACTIVE - 1)) &&
                  ((32'(w_x) + 32'(r_trunc_cnt)) >= 32'(H_ACTIVE));
    end

    // Per-frame configuration captured on entry to the front porch
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            r_mode      <= '0;
            r_fmt       <= 1'b0;
            r_const_pix <= '0;
            r_trunc_en  <= 1'b0;
            r_trunc_cnt <= '0;
        end else if (w_tick && w_latch) begin
            r_mode      <= mode;
            r_fmt       <= fmt;
            r_const_pix <= const_pix;
            r_trunc_en  <= trunc_en;
            r_trunc_cnt <= trunc_cnt;
        end
    end

    // Registered video outputs, frame counter and end-of-frame strobe
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            p_data     <= 8'h00;
            frame_cnt  <= 16'h0000;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_tick) begin
                vsync      <= (w_state_nxt == S_SYNC);
                href       <= (w_state_nxt == S_ACTIVE) && !w_trunc;
                p_data     <= (w_state_nxt == S_ACTIVE) ? w_byte : 8'h00;
                busy       <= (w_state_nxt != S_IDLE);
                frame_done <= w_frame_end;
                if (w_frame_end) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/ov7670_timing_gen.md
Name: ov7670_timing_gen

Overview:
- Synthesizable, parametrised OV7670-style camera source: generates p_clock, vsync, href and 8-bit p_data from a single xclk.
- Successor to the behavioural camera model. Adds configurable resolution, blanking and pclk divider; RGB565/RGB444 output formats; selectable test patterns; programmable last-line href truncation; frame counting.
- Drives the capture front-end in simulation and in hardware self-test, replacing image-file playback.

Parameters:
- H_ACTIVE, 640, active pixels per line (multiple of 8)
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 144, pclk periods of href-low after each active line
- V_FRONT, 10, line periods before vsync
- V_SYNC, 3, line periods vsync high
- V_BACK, 17, line periods after vsync before first active line
- PCLK_DIV, 2, xclk cycles per p_clock period (even, >=2)
- TRUNC_W, 10, width of trunc_cnt

Ports:
- xclk  input  1  sole clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  level; start/continue frame generation
- mode  input  2  0 colour bars, 1 ramp, 2 constant, 3 frame-tag
- fmt  input  1  0 RGB565, 1 RGB444
- const_pix  input  16  pixel value for mode 2
- trunc_en  input  1  enable last-line href truncation
- trunc_cnt  input  TRUNC_W  pixels with href suppressed at end of last line
- p_clock  output  1  pixel clock, xclk/PCLK_DIV, 50% duty
- vsync  output  1  frame sync, active high
- href  output  1  byte-valid qualifier
- p_data  output  8  pixel byte
- frame_cnt  output  16  completed frames, wraps
- frame_done  output  1  one-xclk pulse at frame end
- busy  output  1  high outside IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0.
- Tick: a one-xclk strobe every PCLK_DIV cycles. p_clock falls on the tick and rises PCLK_DIV/2 cycles later.
  - vsync, href and p_data change only on ticks, so they are stable at p_clock rising.
  - The divider free-runs after reset, including in IDLE.
- One line = H_ACTIVE*2 + H_BLANK pclk periods (Lp).
- States:
  - IDLE -> FRONT: on the first tick with enable=1.
  - FRONT (V_FRONT*Lp ticks, vsync=0) -> SYNC.
  - SYNC (V_SYNC*Lp ticks, vsync=1) -> BACK.
  - BACK (V_BACK*Lp ticks) -> ACTIVE.
  - ACTIVE (H_ACTIVE*2 ticks, href=1) -> HBLANK.
  - HBLANK (H_BLANK ticks, href=0, p_data=0) -> ACTIVE if lines remain. After line V_ACTIVE-1: -> FRONT if enable, else IDLE.
- enable deasserted mid-frame: the frame completes; no abort.
- mode, fmt, const_pix, trunc_en and trunc_cnt are latched on FRONT entry and held for the frame.
- Pixel x (0..H_ACTIVE-1), y (0..V_ACTIVE-1). Two bytes per pixel, byte0 first.
  - RGB565: byte0 = pix[15:8], byte1 = pix[7:0].
  - RGB444: byte0 = {4'h0, pix[15:12]}, byte1 = {pix[10:7], pix[4:1]}.
- Pattern pix, by mode:
  - Mode 0: 8 equal bars of H_ACTIVE/8 pixels: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Mode 1: {x[4:0], x[5:0], x[4:0]}.
  - Mode 2: const_pix.
  - Mode 3: {frame_cnt[7:0], y[7:0]}.
- Truncation: if trunc_en and y==V_ACTIVE-1, href=0 for both bytes of pixels x >= H_ACTIVE - trunc_cnt.
  - p_data is still driven with pattern data.
  - trunc_cnt >= H_ACTIVE suppresses the whole line; trunc_cnt=0 suppresses nothing.
- frame_done and frame_cnt: at the final HBLANK tick of each frame, frame_done pulses and frame_cnt increments (FFFF -> 0000).
- Asynchronous reset mid-frame: immediate return to IDLE with all outputs 0. The next frame starts from FRONT with frame_cnt=0.

Test Plan:
- Common parameters: H_ACTIVE=16, V_ACTIVE=4, H_BLANK=8, V_FRONT=2, V_SYNC=1, V_BACK=2, PCLK_DIV=2, so Lp=40.
- Timing: enable=1, mode 2, const_pix=F81F, fmt 0 -> vsync high for 40 pclk starting 80 pclk after start; first href rises 80 pclk after vsync falls; 4 lines of 32 bytes alternating F8, 1F; href low 8 pclk between lines.
- Colour bars RGB444: mode 0, fmt 1 -> line bytes are 0F,FF for x0-1 … 00,00 for x14-15; bar 2 (x4-5) bytes 00,FF; identical on every line.
- Truncation: trunc_en=1, trunc_cnt=3 -> last line has href high for 26 pclk then low; earlier lines have 32. trunc_cnt=20 -> last line has no href at all.
- Frame counting: enable held for 3 frames, mode 3 -> frame_done pulses 3 times; the first byte of line y in frame f is f; frame_cnt=3. Deassert enable mid-frame 4 -> frame 4 completes, busy falls, frame_cnt=4.
- Reset mid-frame: assert reset during ACTIVE -> p_clock, href, vsync, p_data, frame_cnt and busy are 0 the same cycle. Release reset -> restart begins at FRONT.
- Divider: PCLK_DIV=4 -> p_clock is 2 xclk high and 2 xclk low; data changes only at p_clock falling.
